// File: rtl/avg_divider_pipe.sv
// avg_divider_pipe: divides an unsigned dividend by one of four
// elaboration-time divisors using a precomputed reciprocal multiply.
// Valid/ready pipeline with three register stages:
//   S1 bias add + reciprocal select, S2 multiply, S3 shift + saturate.
//
// Build option: define AVG_DIV_ROUND_EN for round-half-up
// floor((x + floor(D/2)) / D). Leave it undefined for truncating
// floor(x / D). The ports are the same in both builds.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous, active-high reset
//   valid_i     input beat valid
//   ready_o     a beat is accepted when valid_i & ready_o
//   dividend_i  unsigned dividend, DIVIDEND_W bits
//   sel_i       divisor select 0..3 -> DIV0..DIV3, sampled with the beat
//   valid_o     output beat valid
//   ready_i     downstream accepts when valid_o & ready_i
//   quotient_o  quotient, QUOTIENT_W bits, all ones when saturated
//   sat_o       the current beat saturated
module avg_divider_pipe #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned QUOTIENT_W = 12,
  parameter int unsigned FRAC_W     = 24,
  parameter int unsigned DIV0       = 1,
  parameter int unsigned DIV1       = 9,
  parameter int unsigned DIV2       = 25,
  parameter int unsigned DIV3       = 49
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [1:0]            sel_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [QUOTIENT_W-1:0] quotient_o,
  output logic                  sat_o
);

`ifdef AVG_DIV_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int unsigned MAX01   = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned MAX23   = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned MAX_DIV = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned SUM_W   = DIVIDEND_W + 1;   // bias add can never wrap
  localparam int unsigned RCP_W   = FRAC_W + 1;       // D=1 needs 2^FRAC_W exactly
  localparam int unsigned PROD_W  = SUM_W + RCP_W;
  localparam int unsigned QF_W    = PROD_W - FRAC_W;
  localparam int unsigned CMP_W   = (QF_W > QUOTIENT_W) ? QF_W : QUOTIENT_W;

  // The reciprocal error stays below one LSB of the quotient only when
  // FRAC_W covers the widened dividend plus the divisor magnitude.
  if (FRAC_W < DIVIDEND_W + 1 + $clog2(MAX_DIV) ||
      DIV0 < 1 || DIV1 < 1 || DIV2 < 1 || DIV3 < 1) begin : g_param_check
    $error("avg_divider_pipe: FRAC_W too small or a divisor is zero");
  end

  function automatic logic [RCP_W-1:0] recip(input longint unsigned d);
    return RCP_W'(((64'd1 << FRAC_W) + d - 64'd1) / d);
  endfunction

  function automatic logic [SUM_W-1:0] bias(input longint unsigned d);
    return SUM_W'(ROUND_EN ? (d / 64'd2) : 64'd0);
  endfunction

  localparam logic [RCP_W-1:0] RCP0  = recip(64'(DIV0));
  localparam logic [RCP_W-1:0] RCP1  = recip(64'(DIV1));
  localparam logic [RCP_W-1:0] RCP2  = recip(64'(DIV2));
  localparam logic [RCP_W-1:0] RCP3  = recip(64'(DIV3));
  localparam logic [SUM_W-1:0] BIAS0 = bias(64'(DIV0));
  localparam logic [SUM_W-1:0] BIAS1 = bias(64'(DIV1));
  localparam logic [SUM_W-1:0] BIAS2 = bias(64'(DIV2));
  localparam logic [SUM_W-1:0] BIAS3 = bias(64'(DIV3));
  localparam logic [CMP_W-1:0] QMAX  = CMP_W'({QUOTIENT_W{1'b1}});

  logic                  s1_valid_q, s2_valid_q, s3_valid_q;
  logic                  s1_adv, s2_adv, s3_adv;
  logic [SUM_W-1:0]      s1_sum_d, s1_sum_q, s1_bias;
  logic [RCP_W-1:0]      s1_rcp_d, s1_rcp_q;
  logic [PROD_W-1:0]     s2_prod_d, s2_prod_q;
  logic [CMP_W-1:0]      s3_qfull;
  logic                  s3_sat_d, sat_q;
  logic [QUOTIENT_W-1:0] s3_quot_d, quotient_q;

  // Advance chain runs from the output back to the input, so
  // ready_o depends combinationally on ready_i.
  assign s3_adv  = ~s3_valid_q | ready_i;
  assign s2_adv  = ~s2_valid_q | s3_adv;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign ready_o = s1_adv;

  assign valid_o    = s3_valid_q;
  assign quotient_o = quotient_q;
  assign sat_o      = sat_q;

  // S1: pick the divisor constants that travel with this beat.
  always_comb begin
    s1_rcp_d = RCP0;
    s1_bias  = BIAS0;
    case (sel_i)
      2'd0: begin s1_rcp_d = RCP0; s1_bias = BIAS0; end
      2'd1: begin s1_rcp_d = RCP1; s1_bias = BIAS1; end
      2'd2: begin s1_rcp_d = RCP2; s1_bias = BIAS2; end
      2'd3: begin s1_rcp_d = RCP3; s1_bias = BIAS3; end
    endcase
    s1_sum_d = {1'b0, dividend_i} + s1_bias;
  end

  // S2: full-width product.
  always_comb begin
    s2_prod_d = PROD_W'(s1_sum_q) * PROD_W'(s1_rcp_q);
  end

  // S3: drop the fraction bits, then clamp to the quotient width.
  always_comb begin
    s3_qfull  = CMP_W'(s2_prod_q >> FRAC_W);
    s3_sat_d  = (s3_qfull > QMAX);
    s3_quot_d = s3_sat_d ? '1 : s3_qfull[QUOTIENT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      quotient_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= valid_i;
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s3_adv) begin
        s3_valid_q <= s2_valid_q;
        // Output data only changes with a real beat, so it stays put
        // while stalled and keeps its reset value until the first result.
        if (s2_valid_q) begin
          quotient_q <= s3_quot_d;
          sat_q      <= s3_sat_d;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_adv && valid_i) begin
      s1_sum_q <= s1_sum_d;
      s1_rcp_q <= s1_rcp_d;
    end
    if (s2_adv && s1_valid_q) begin
      s2_prod_q <= s2_prod_d;
    end
  end

endmodule

// File: tb/tb_avg_divider_pipe.sv
// Directed testbench for avg_divider_pipe (default parameters).
// Expected values follow AVG_DIV_ROUND_EN when it is defined.
module tb_avg_divider_pipe;

`ifdef AVG_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, ready_i, valid_o, sat_o;
  logic [15:0] dividend_i;
  logic [1:0]  sel_i;
  logic [11:0] quotient_o;

  int total = 0;
  int bad   = 0;

  avg_divider_pipe #(
    .DIVIDEND_W (16),
    .QUOTIENT_W (12),
    .FRAC_W     (24),
    .DIV0       (1),
    .DIV1       (9),
    .DIV2       (25),
    .DIV3       (49)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .dividend_i (dividend_i),
    .sel_i      (sel_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .quotient_o (quotient_o),
    .sat_o      (sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned divisor(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 9;
      2'd2: return 25;
      default: return 49;
    endcase
  endfunction

  // Reference: integer division, then clamp to 12 bits. Result {sat, quotient}.
  function automatic logic [12:0] model(input logic [15:0] x, input logic [1:0] s);
    int unsigned d, v;
    d = divisor(s);
    v = (int'(x) + (ROUND ? d / 2 : 0)) / d;
    if (v > 4095) return {1'b1, 12'hFFF};
    return {1'b0, v[11:0]};
  endfunction

  // One isolated beat: checks 3-cycle latency and the hand-computed result.
  task automatic one_beat(input string tag, input logic [15:0] x, input logic [1:0] s,
                          input int unsigned exp_q, input bit exp_sat);
    valid_i = 1'b1; dividend_i = x; sel_i = s; ready_i = 1'b1;
    chk({tag, " rdy"}, ready_o, 1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk({tag, " lat1"}, valid_o, 0);
    @(posedge clk_i); #1;
    chk({tag, " lat2"}, valid_o, 0);
    @(posedge clk_i); #1;
    chk({tag, " vld"}, valid_o, 1);
    chk({tag, " q"}, quotient_o, exp_q);
    chk({tag, " sat"}, sat_o, exp_sat);
    @(posedge clk_i); #1;
    chk({tag, " gone"}, valid_o, 0);
  endtask

  logic [15:0] bx [5];
  logic [1:0]  bs [5];
  logic [12:0] sb [$];
  logic [12:0] e;
  int          acc, n;
  bit          in_fire, out_fire;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; dividend_i = '0; sel_i = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst valid_o", valid_o, 0);
    chk("rst sat_o", sat_o, 0);
    chk("rst quotient_o", quotient_o, 0);
    rst_i = 1'b0;
    #1;
    chk("rst ready_o", ready_o, 1);
    @(posedge clk_i); #1;

    // Single beats with hand-computed results
    one_beat("80/9", 16'd80, 2'd1, ROUND ? 9 : 8, 1'b0);
    one_beat("65535/1", 16'd65535, 2'd0, 4095, 1'b1);
    one_beat("4096/1", 16'd4096, 2'd0, 4095, 1'b1);
    one_beat("65535/49", 16'd65535, 2'd3, 1337, 1'b0);
    one_beat("0/49", 16'd0, 2'd3, 0, 1'b0);
    one_beat("25/49", 16'd25, 2'd3, ROUND ? 1 : 0, 1'b0);
    one_beat("13/25", 16'd13, 2'd2, ROUND ? 1 : 0, 1'b0);

    // Back-to-back beats, one per cycle, sel changing every beat
    bx[0] = 16'd5;    bs[0] = 2'd1;
    bx[1] = 16'd4;    bs[1] = 2'd1;
    bx[2] = 16'd100;  bs[2] = 2'd2;
    bx[3] = 16'd4095; bs[3] = 2'd0;
    ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        valid_i = 1'b1; dividend_i = bx[c]; sel_i = bs[c];
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk_i); #1;
      if (c >= 2 && c < 6) begin
        chk($sformatf("burst vld %0d", c - 2), valid_o, 1);
        case (c - 2)
          0: chk("burst 5/9", {sat_o, quotient_o}, ROUND ? 1 : 0);
          1: chk("burst 4/9", {sat_o, quotient_o}, 0);
          2: chk("burst 100/25", {sat_o, quotient_o}, 4);
          default: chk("burst 4095/1", {sat_o, quotient_o}, 4095);
        endcase
      end else if (c >= 6) begin
        chk($sformatf("burst idle %0d", c), valid_o, 0);
      end
    end

    // Backpressure: ready_i low for 6 cycles, 5 beats offered back to back
    bx[0] = 16'd4096;  bs[0] = 2'd0;
    bx[1] = 16'd80;    bs[1] = 2'd1;
    bx[2] = 16'd65535; bs[2] = 2'd3;
    bx[3] = 16'd30;    bs[3] = 2'd2;
    bx[4] = 16'd50;    bs[4] = 2'd2;
    ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      valid_i = 1'b1; dividend_i = bx[acc]; sel_i = bs[acc];
      #1;
      in_fire = ready_o;
      @(posedge clk_i); #1;
      if (in_fire) acc++;
      if (c >= 2) begin
        e = model(bx[0], bs[0]);
        chk($sformatf("bp hold vld %0d", c), valid_o, 1);
        chk($sformatf("bp hold q %0d", c), {sat_o, quotient_o}, e);
      end
    end
    chk("bp accepted", acc, 3);
    chk("bp ready_o", ready_o, 0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (valid_o) begin
        if (n < 3) begin
          e = model(bx[n], bs[n]);
          chk($sformatf("bp out %0d", n), {sat_o, quotient_o}, e);
        end
        n++;
      end
      @(posedge clk_i); #1;
    end
    chk("bp out count", n, 3);

    // Reset with two beats in flight
    ready_i = 1'b1;
    valid_i = 1'b1; dividend_i = 16'd200; sel_i = 2'd1;
    @(posedge clk_i); #1;
    dividend_i = 16'd300; sel_i = 2'd2;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("pre-rst valid_o", valid_o, 1);
    rst_i = 1'b1;
    #1;
    chk("rst async valid_o", valid_o, 0);
    chk("rst async sat_o", sat_o, 0);
    chk("rst async quotient_o", quotient_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("post-rst ready_o", ready_o, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      chk($sformatf("no stale %0d", c), valid_o, 0);
    end
    one_beat("post-rst 80/9", 16'd80, 2'd1, ROUND ? 9 : 8, 1'b0);

    // Random valid/ready sweep against the reference model
    for (int c = 0; c < 4000; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      sel_i   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: dividend_i = 16'hFFFF;
        1: dividend_i = 16'd0;
        2: dividend_i = 16'($urandom_range(4090, 4100));
        3: dividend_i = 16'($urandom_range(0, 100));
        default: dividend_i = 16'($urandom_range(0, 65535));
      endcase
      #1;
      in_fire  = valid_i && ready_o;
      out_fire = valid_o && ready_i;
      if (out_fire) begin
        if (sb.size() == 0) begin
          chk("sweep spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sweep result", {sat_o, quotient_o}, e);
        end
      end
      if (in_fire) sb.push_back(model(dividend_i, sel_i));
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("drain spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("drain result", {sat_o, quotient_o}, e);
        end
      end
      @(posedge clk_i); #1;
    end
    chk("drain empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
